// File: rtl/fifo_level_tracker_pkg.sv
// fifo_pkg: shared FIFO widths, default thresholds and status flag bundle.
package fifo_pkg;

  localparam int DEF_DEPTH     = 4;
  localparam int DEF_AE_THRESH = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int def_af_thresh(input int depth);
    return depth - 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_level_tracker_if.sv
// fifo_level_tracker_if: push/pop strobes and occupancy status between FIFO control and the tracker.
interface fifo_level_tracker_if #(
  parameter int CNT_W = fifo_pkg::cnt_width(fifo_pkg::DEF_DEPTH)
) ();
  logic             increment;
  logic             decrement;
  logic             clear_errors;
  logic             clear_peak;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] peak;

  modport master (
    output increment, decrement, clear_errors, clear_peak,
    input  count, full, empty, almost_full, almost_empty, overflow, underflow, peak
  );

  modport slave (
    input  increment, decrement, clear_errors, clear_peak,
    output count, full, empty, almost_full, almost_empty, overflow, underflow, peak
  );
endinterface

// File: rtl/fifo_peak_tracker.sv
// fifo_peak_tracker: high-water mark of the next occupancy, reloadable on clear_peak.
module fifo_peak_tracker #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_next,
  input  logic             clear_peak,
  output logic [CNT_W-1:0] peak
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) peak <= '0;
    else if (clear_peak || count_next > peak) peak <= count_next;
  end
endmodule

// File: rtl/fifo_level_tracker.sv
// fifo_level_tracker: saturating FIFO occupancy counter with registered flags,
// sticky overflow/underflow and a clearable high-water mark.
module fifo_level_tracker
  import fifo_pkg::*;
#(
  parameter int  DEPTH     = DEF_DEPTH,
  parameter int  AF_THRESH = def_af_thresh(DEPTH),
  parameter int  AE_THRESH = DEF_AE_THRESH,
  localparam int CNT_W     = cnt_width(DEPTH)
) (
  input logic clk,
  input logic reset,
  fifo_level_tracker_if.slave bus
);
  if (DEPTH < 1 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
    $fatal(1, "fifo_level_tracker: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  logic [CNT_W-1:0] count, count_next, peak;
  logic             push, pop, ovf_evt, unf_evt;
  fifo_status_t     st, st_next;

  // Simultaneous push and pop is a pass-through: level holds and no error is raised.
  always_comb begin
    push       = bus.increment & ~bus.decrement;
    pop        = bus.decrement & ~bus.increment;
    ovf_evt    = push & (count == FULL_C);
    unf_evt    = pop & (count == '0);
    count_next = (push & ~ovf_evt) ? count + 1'b1 : (pop & ~unf_evt) ? count - 1'b1 : count;
    st_next    = '{
      full:         count_next == FULL_C,
      empty:        count_next == '0,
      almost_full:  count_next >= AF_C,
      almost_empty: count_next <= AE_C,
      overflow:     ovf_evt | (st.overflow & ~bus.clear_errors),
      underflow:    unf_evt | (st.underflow & ~bus.clear_errors)
    };
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      st    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                 overflow: 1'b0, underflow: 1'b0};
    end else begin
      count <= count_next;
      st    <= st_next;
    end
  end

  fifo_peak_tracker #(.CNT_W(CNT_W)) u_peak (
    .clk        (clk),
    .reset      (reset),
    .count_next (count_next),
    .clear_peak (bus.clear_peak),
    .peak       (peak)
  );

  assign bus.count        = count;
  assign bus.peak         = peak;
  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;
endmodule

// File: tb/tb_fifo_level_tracker.sv
// tb_fifo_level_tracker: table vectors, async-reset sequence and random traffic against a level model.
module tb_fifo_level_tracker;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_level_tracker_if #(.CNT_W(3)) bus ();

  fifo_level_tracker #(.DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       inc, dec, ce, cp;
    int       cnt;
    bit [3:0] flg;
    bit       ov, un;
    int       pk;
  } vec_t;

  int  errors = 0;
  int  checks = 0;
  int  m_cnt, m_peak;
  bit  m_ov, m_un;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(bit inc, bit dec, bit ce, bit cp, int cnt, bit [3:0] flg, bit ov, bit un, int pk);
    vec_t r;
    r.inc = inc; r.dec = dec; r.ce = ce; r.cp = cp;
    r.cnt = cnt; r.flg = flg; r.ov = ov; r.un = un; r.pk = pk;
    return r;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_peak = 0; m_ov = 0; m_un = 0;
  endfunction

  function automatic void model_step(bit inc, bit dec, bit ce, bit cp);
    bit ev_ov, ev_un;
    ev_ov = 0; ev_un = 0;
    if (inc && !dec) begin
      if (m_cnt == DEPTH) ev_ov = 1; else m_cnt++;
    end else if (dec && !inc) begin
      if (m_cnt == 0) ev_un = 1; else m_cnt--;
    end
    m_ov = ev_ov || (m_ov && !ce);
    m_un = ev_un || (m_un && !ce);
    if (cp || m_cnt > m_peak) m_peak = m_cnt;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " count"}, int'(bus.count), m_cnt);
    chk({tag, " full"}, int'(bus.full), int'(m_cnt == DEPTH));
    chk({tag, " empty"}, int'(bus.empty), int'(m_cnt == 0));
    chk({tag, " almost_full"}, int'(bus.almost_full), int'(m_cnt >= AF));
    chk({tag, " almost_empty"}, int'(bus.almost_empty), int'(m_cnt <= AE));
    chk({tag, " overflow"}, int'(bus.overflow), int'(m_ov));
    chk({tag, " underflow"}, int'(bus.underflow), int'(m_un));
    chk({tag, " peak"}, int'(bus.peak), m_peak);
  endtask

  task automatic tick(input bit inc, input bit dec, input bit ce, input bit cp);
    bus.increment = inc; bus.decrement = dec; bus.clear_errors = ce; bus.clear_peak = cp;
    @(posedge clk);
    #1;
    model_step(inc, dec, ce, cp);
    bus.increment = 0; bus.decrement = 0; bus.clear_errors = 0; bus.clear_peak = 0;
  endtask

  initial begin
    bus.increment = 0; bus.decrement = 0; bus.clear_errors = 0; bus.clear_peak = 0;
    model_reset();
    // flg = {full, empty, almost_full, almost_empty}
    tbl.push_back(v(1,0,0,0, 1, 4'b0001, 0,0, 1));
    tbl.push_back(v(1,0,0,0, 2, 4'b0000, 0,0, 2));
    tbl.push_back(v(1,0,0,0, 3, 4'b0010, 0,0, 3));
    tbl.push_back(v(1,0,0,0, 4, 4'b1010, 0,0, 4));
    tbl.push_back(v(1,0,0,0, 4, 4'b1010, 1,0, 4));
    tbl.push_back(v(0,0,1,0, 4, 4'b1010, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 3, 4'b0010, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 2, 4'b0000, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 1, 4'b0001, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 0, 4'b0101, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 0, 4'b0101, 0,1, 4));
    tbl.push_back(v(0,0,1,0, 0, 4'b0101, 0,0, 4));
    tbl.push_back(v(1,1,0,0, 0, 4'b0101, 0,0, 4));
    tbl.push_back(v(1,0,0,0, 1, 4'b0001, 0,0, 4));
    tbl.push_back(v(1,0,0,0, 2, 4'b0000, 0,0, 4));
    tbl.push_back(v(1,1,0,0, 2, 4'b0000, 0,0, 4));
    tbl.push_back(v(1,0,0,0, 3, 4'b0010, 0,0, 4));
    tbl.push_back(v(1,0,0,0, 4, 4'b1010, 0,0, 4));
    tbl.push_back(v(1,1,0,0, 4, 4'b1010, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 3, 4'b0010, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 2, 4'b0000, 0,0, 4));
    tbl.push_back(v(0,1,0,0, 1, 4'b0001, 0,0, 4));
    tbl.push_back(v(0,0,0,1, 1, 4'b0001, 0,0, 1));
    tbl.push_back(v(1,0,0,0, 2, 4'b0000, 0,0, 2));
    tbl.push_back(v(0,1,0,0, 1, 4'b0001, 0,0, 2));
    tbl.push_back(v(0,1,0,0, 0, 4'b0101, 0,0, 2));
    tbl.push_back(v(0,1,1,0, 0, 4'b0101, 0,1, 2));

    #12;
    chk("reset count", int'(bus.count), 0);
    chk("reset flags", int'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}), 4'b0101);
    chk("reset errors", int'({bus.overflow, bus.underflow}), 0);
    chk("reset peak", int'(bus.peak), 0);
    @(negedge clk) reset = 0;

    foreach (tbl[i]) begin
      tick(tbl[i].inc, tbl[i].dec, tbl[i].ce, tbl[i].cp);
      chk($sformatf("vec%0d count", i), int'(bus.count), tbl[i].cnt);
      chk($sformatf("vec%0d flags", i), int'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}), int'(tbl[i].flg));
      chk($sformatf("vec%0d overflow", i), int'(bus.overflow), int'(tbl[i].ov));
      chk($sformatf("vec%0d underflow", i), int'(bus.underflow), int'(tbl[i].un));
      chk($sformatf("vec%0d peak", i), int'(bus.peak), tbl[i].pk);
    end

    // Mid-cycle asynchronous reset at count 3 with underflow still set.
    repeat (3) tick(1, 0, 0, 0);
    chk("pre-reset count", int'(bus.count), 3);
    chk("pre-reset underflow", int'(bus.underflow), 1);
    #2 reset = 1;
    #1;
    model_reset();
    check_model("async reset");
    @(negedge clk) reset = 0;
    tick(1, 0, 0, 0);
    chk("post-reset count", int'(bus.count), 1);
    check_model("post-reset");

    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) == 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_level_tracker.md
Name: fifo_level_tracker

Overview:
Parametrised FIFO occupancy tracker and the successor to the fixed 2-bit push/pop counter. It tracks the FIFO fill level from push (increment) and pop (decrement) strobes. It produces registered full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a clearable high-water mark. It sits beside the FIFO storage and pointer logic, and the FIFO control and status logic consume its outputs.

Parameters:
DEPTH, 4, FIFO capacity in entries; legal range is DEPTH >= 1.
CNT_W, $clog2(DEPTH+1), width of count and peak; derived, not overridden.
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range is 0 <= AE_THRESH < AF_THRESH <= DEPTH.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high reset.
increment  in  1  push strobe, one entry per cycle.
decrement  in  1  pop strobe, one entry per cycle.
clear_errors  in  1  synchronous clear of overflow/underflow.
clear_peak  in  1  synchronous reload of peak.
count  out  CNT_W  current occupancy, range 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
overflow  out  1  sticky; a push was attempted while full.
underflow  out  1  sticky; a pop was attempted while empty.
peak  out  CNT_W  highest count since reset or the last clear_peak.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): count=0, peak=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=0.
- All outputs are registered. Flags are computed from count_next, so flags always agree with count in the same cycle. Latency from a strobe to the updated count and flags is 1 cycle.
- count_next rules:
  - increment only, count < DEPTH: count+1.
  - increment only, count == DEPTH: count holds; overflow <= 1.
  - decrement only, count > 0: count-1.
  - decrement only, count == 0: count holds; underflow <= 1.
  - increment and decrement together: count holds at every level, including 0 and DEPTH (simultaneous push/pop or pass-through). No error is flagged.
  - neither strobe: count holds.
- count never wraps. Arithmetic is done at CNT_W bits and saturates via the guards above.
- Sticky errors stay set until clear_errors. If clear_errors and a new error event occur in the same cycle, set wins and the flag stays 1.
- Peak:
  - Normal update: peak <= count_next when count_next > peak.
  - clear_peak: peak <= count_next, which takes priority over the normal update.
- Parameter legality is checked at elaboration. An illegal DEPTH or threshold set stops elaboration with a fatal error.

Decomposition:
- Shared package fifo_pkg holds:
  - a width helper returning CNT_W for a given depth;
  - the default threshold constants;
  - a status struct bundling the full, empty, almost_full, almost_empty, overflow and underflow flags, for reuse by other FIFO blocks.
- One sub-module, fifo_peak_tracker (CNT_W parameter; inputs count_next and clear_peak; output peak).
- The counter, flag and error logic stays in the top module.

Test Plan:
All scenarios use DEPTH=4, AF_THRESH=3, AE_THRESH=1.
- Reset, then 4 increment-only cycles -> count 1,2,3,4. almost_empty drops when count reaches 2. almost_full rises at 3, full at 4. peak=4.
- At count=4, one increment-only cycle -> count stays 4, overflow=1. Then clear_errors -> overflow=0 the next cycle.
- Drain from 4 with 5 decrement-only cycles -> count 3,2,1,0,0. empty=1 at 0. underflow=1 on the 5th pop. peak still 4.
- increment+decrement together at count 0, 2 and 4 -> count unchanged each time, with no overflow or underflow.
- At count=1 with peak=4, assert clear_peak -> peak=1. Then 1 increment -> peak=2. Also drive clear_errors together with a pop at empty -> underflow stays 1.
- Assert reset asynchronously mid-cycle at count=3 with underflow set -> all outputs take their reset values immediately, without waiting for a clock edge. Counting resumes normally after reset is released.
